meas_result_buf: RTL and testbench
==================================

// Module: meas_result_buf
// PURPOSE
//  Producer end of the REGSRC_MEA writeback path. Captures qubit measurement results from the
//  readout chain and serves fetch-measurement-result (FMR) requests from the pipeline.
//  o_meas_data feeds i_from_q_measure of the register-writeback mux. It stalls the pipeline
//  until the requested qubit's result has arrived or a timeout expires.
// PARAMETERS
//  NUM_QUBITS      8     number of qubit result slots
//  QIDX_W          3     qubit index width; must satisfy 2**QIDX_W >= NUM_QUBITS
//  TIMEOUT_CYCLES  4096  maximum WAIT cycles before an error response; must be >= 1
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       reset: synchronous, active-high
//  i_mr_valid     in   1       readout result strobe; one result per cycle; no backpressure
//  i_mr_qidx      in   QIDX_W  qubit index of the result
//  i_mr_bit       in   1       measured value
//  i_fmr_req      in   1       FMR request; held high by pipeline while o_stall=1
//  i_fmr_qidx     in   QIDX_W  qubit to fetch; stable while i_fmr_req=1
//  i_flush        in   1       pipeline flush; cancels any pending request
//  o_meas_data    out  32      writeback value; valid when o_fmr_done=1
//  o_fmr_done     out  1       one-cycle response pulse
//  o_stall        out  1       pipeline stall request
//  o_timeout_err  out  1       sticky: an FMR timed out or used an out-of-range index
//  o_overrun      out  1       sticky: a result overwrote an unconsumed result
// BEHAVIOUR
//  Reset (sync, active-high)
//   - All slot valid flags are cleared; the FSM goes to IDLE.
//   - o_meas_data=0, o_fmr_done=0, o_timeout_err=0, o_overrun=0, wait counter=0.
//  Store
//   - i_mr_valid with qidx<NUM_QUBITS writes bit[qidx] and sets vld[qidx].
//   - If vld[qidx] is already set and is not consumed in the same cycle: the slot is overwritten and o_overrun is set.
//   - A result with qidx>=NUM_QUBITS is dropped.
//  Availability
//   - avail = vld[i_fmr_qidx], OR (i_mr_valid AND i_mr_qidx==i_fmr_qidx). Same-cycle bypass.
//  FSM
//   - IDLE
//     - On i_fmr_req & !i_flush with an out-of-range index: go to RESP, data=32'hFFFF_FFFF, set o_timeout_err.
//     - Else if avail: go to RESP, data={31'b0,bit}, where bit is the bypassed i_mr_bit when the bypass term is active.
//     - Else: go to WAIT with counter=0.
//   - WAIT
//     - i_flush: go to IDLE, no response.
//     - Else if avail: go to RESP with the result, as in IDLE.
//     - Else if counter==TIMEOUT_CYCLES-1: go to RESP, data=32'hFFFF_FFFF, set o_timeout_err.
//     - Else: counter+1.
//   - RESP
//     - o_fmr_done=1 for exactly one cycle, then go to IDLE.
//     - o_meas_data holds its value until the next response.
//  Consume
//   - On a successful IDLE/WAIT->RESP transition, vld[qidx] is cleared in that same cycle.
//   - An incoming result for the same qubit in that same cycle is returned and is not retained.
//  Stall
//   - o_stall = i_fmr_req & (state!=RESP) & !i_flush; combinational, so the stall covers the request cycle.
//   - Minimum latency: request cycle N, o_fmr_done at N+1.
//  Flush
//   - i_flush in RESP does not suppress that cycle's o_fmr_done; the pipeline discards it.
//  Reset mid-WAIT
//   - The request is aborted silently and no o_fmr_done is issued.
//  Sticky flags
//   - o_timeout_err and o_overrun clear only on rst.
// STRUCTURE
//  Shared package cc_pkg
//   - meas_state_t enum {IDLE,WAIT,RESP}
//   - MEAS_ERR_DATA = 32'hFFFF_FFFF
//  Sub-module meas_slot_array
//   - Holds the per-qubit bit/vld registers, write port, consume-clear port and bypass logic.
//   - The top level holds the FSM, wait counter and sticky flags.
// TESTING
//  1. Result q3=1, then FMR q3 two cycles later -> no stall in a WAIT state; o_fmr_done the next cycle; data=32'h1; vld[3]=0.
//  2. FMR q5 at t0, result q5=0 at t0+10 -> o_stall high for t0..t0+10; done at t0+11; data=32'h0.
//  3. FMR q2 with TIMEOUT_CYCLES=16 and no result
//     -> done after 17 cycles in total (1 IDLE cycle + 16 WAIT cycles);
//     -> data=32'hFFFF_FFFF; o_timeout_err=1 and it persists afterwards.
//  4. Result q1=1 in the same cycle as FMR q1 from IDLE -> done the next cycle with data=1; a second FMR q1 then stalls.
//  5. Results q4=0 then q4=1 with no FMR in between -> o_overrun=1; FMR q4 returns 32'h1.
//  6. FMR q6 in WAIT, then i_flush -> IDLE and no done. Separately, rst asserted in WAIT -> all outputs 0 next cycle; no done.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types for the measurement-result writeback path.
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } meas_state_t;

  localparam logic [31:0] MEAS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/meas_slot_array.sv
// Per-qubit result slots: write port, consume-clear port and same-cycle bypass to the reader.
module meas_slot_array
  import cc_pkg::*;
#(
  parameter int NUM_QUBITS = 8,
  parameter int QIDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [QIDX_W-1:0] wr_qidx,
  input  logic              wr_bit,
  input  logic [QIDX_W-1:0] rd_qidx,
  input  logic              consume,
  output logic              rd_in_range,
  output logic              avail,
  output logic              rd_bit,
  output logic              overrun
);

  // Storage covers the full index space so no index can fall outside the vectors.
  localparam int SLOTS = 1 << QIDX_W;

  logic [SLOTS-1:0] bits;
  logic [SLOTS-1:0] vld;
  logic             wr_ok;
  logic             bypass;
  logic             same_slot_consume;

  assign rd_in_range       = 32'(rd_qidx) < NUM_QUBITS;
  assign wr_ok             = wr_en && (32'(wr_qidx) < NUM_QUBITS);
  assign bypass            = wr_ok && rd_in_range && (wr_qidx == rd_qidx);
  assign avail             = (rd_in_range && vld[rd_qidx]) || bypass;
  assign rd_bit            = bypass ? wr_bit : bits[rd_qidx];
  assign same_slot_consume = consume && (wr_qidx == rd_qidx);
  assign overrun           = wr_ok && vld[wr_qidx] && !same_slot_consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
      vld  <= '0;
    end else begin
      // A result consumed in its arrival cycle is handed straight to the reader.
      if (wr_ok && !same_slot_consume) begin
        bits[wr_qidx] <= wr_bit;
        vld[wr_qidx]  <= 1'b1;
      end
      if (consume) begin
        vld[rd_qidx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/meas_result_buf.sv
// Captures readout results and answers fetch-measurement-result requests, stalling the
// pipeline until the requested result arrives or the wait times out.
module meas_result_buf
  import cc_pkg::*;
#(
  parameter int NUM_QUBITS     = 8,
  parameter int QIDX_W         = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mr_valid,
  input  logic [QIDX_W-1:0] i_mr_qidx,
  input  logic              i_mr_bit,
  input  logic              i_fmr_req,
  input  logic [QIDX_W-1:0] i_fmr_qidx,
  input  logic              i_flush,
  output logic [31:0]       o_meas_data,
  output logic              o_fmr_done,
  output logic              o_stall,
  output logic              o_timeout_err,
  output logic              o_overrun
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  meas_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      data_nxt;
  logic             terr_set;
  logic             consume;
  logic             rd_in_range;
  logic             avail;
  logic             rd_bit;
  logic             overrun_evt;

  meas_slot_array #(
    .NUM_QUBITS (NUM_QUBITS),
    .QIDX_W     (QIDX_W)
  ) u_slots (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (i_mr_valid),
    .wr_qidx     (i_mr_qidx),
    .wr_bit      (i_mr_bit),
    .rd_qidx     (i_fmr_qidx),
    .consume     (consume),
    .rd_in_range (rd_in_range),
    .avail       (avail),
    .rd_bit      (rd_bit),
    .overrun     (overrun_evt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = o_meas_data;
    terr_set  = 1'b0;
    consume   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_fmr_req && !i_flush) begin
          if (!rd_in_range) begin
            state_nxt = RESP;
            data_nxt  = MEAS_ERR_DATA;
            terr_set  = 1'b1;
          end else if (avail) begin
            state_nxt = RESP;
            data_nxt  = {31'b0, rd_bit};
            consume   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        if (i_flush) begin
          state_nxt = IDLE;
        end else if (avail) begin
          state_nxt = RESP;
          data_nxt  = {31'b0, rd_bit};
          consume   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          data_nxt  = MEAS_ERR_DATA;
          terr_set  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      o_meas_data   <= '0;
      o_timeout_err <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      o_meas_data   <= data_nxt;
      o_timeout_err <= o_timeout_err | terr_set;
      o_overrun     <= o_overrun | overrun_evt;
    end
  end

  // Stall is combinational so it already covers the cycle the request is raised.
  assign o_stall    = i_fmr_req && (state != RESP) && !i_flush;
  assign o_fmr_done = (state == RESP);

endmodule

// File: tb/tb_meas_result_buf.sv
// Scoreboarded random + directed bench for meas_result_buf against a slot/request reference model.
module tb_meas_result_buf;

  localparam int NQ = 7;
  localparam int QW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mr_valid;
  logic [QW-1:0] i_mr_qidx;
  logic          i_mr_bit;
  logic          i_fmr_req;
  logic [QW-1:0] i_fmr_qidx;
  logic          i_flush;
  logic [31:0]   o_meas_data;
  logic          o_fmr_done;
  logic          o_stall;
  logic          o_timeout_err;
  logic          o_overrun;

  meas_result_buf #(
    .NUM_QUBITS     (NQ),
    .QIDX_W         (QW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mr_valid    (i_mr_valid),
    .i_mr_qidx     (i_mr_qidx),
    .i_mr_bit      (i_mr_bit),
    .i_fmr_req     (i_fmr_req),
    .i_fmr_qidx    (i_fmr_qidx),
    .i_flush       (i_flush),
    .o_meas_data   (o_meas_data),
    .o_fmr_done    (o_fmr_done),
    .o_stall       (o_stall),
    .o_timeout_err (o_timeout_err),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: stored results, outstanding request and its age, last response.
  logic [7:0]  m_bit, m_vld;
  logic        m_pend, m_resp, m_terr, m_ovr;
  int          m_waited;
  logic [31:0] m_data;
  logic [31:0] sb[$];
  logic        exp_stall;
  logic        want;
  int          wq;
  logic        mon_on = 1'b0;
  logic        final_req = 1'b0;
  logic        final_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic respond(input logic [31:0] d, input logic err);
    sb.push_back(d);
    m_data = d;
    m_resp = 1'b1;
    m_pend = 1'b0;
    if (err) m_terr = 1'b1;
  endtask

  task automatic model_update();
    int   q, mq;
    logic byp, av, ab, cons;
    if (rst) begin
      m_bit = '0; m_vld = '0; m_pend = 0; m_resp = 0;
      m_terr = 0; m_ovr = 0; m_data = '0; m_waited = 0;
      return;
    end
    q    = int'(i_fmr_qidx);
    mq   = int'(i_mr_qidx);
    byp  = i_mr_valid && (mq < NQ) && (mq == q);
    av   = (q < NQ) && (m_vld[q] || byp);
    ab   = byp ? i_mr_bit : m_bit[q];
    cons = 1'b0;
    if (m_resp) begin
      m_resp = 1'b0;
    end else if (!m_pend) begin
      if (i_fmr_req && !i_flush) begin
        if (q >= NQ) respond(32'hFFFF_FFFF, 1'b1);
        else if (av) begin respond({31'b0, ab}, 1'b0); cons = 1'b1; end
        else begin m_pend = 1'b1; m_waited = 0; end
      end
    end else if (i_flush) begin
      m_pend = 1'b0;
    end else if (av) begin
      respond({31'b0, ab}, 1'b0); cons = 1'b1;
    end else if (m_waited == TO - 1) begin
      respond(32'hFFFF_FFFF, 1'b1);
    end else begin
      m_waited++;
    end
    if (i_mr_valid && mq < NQ && !(cons && mq == q)) begin
      if (m_vld[mq]) m_ovr = 1'b1;
      m_bit[mq] = i_mr_bit;
      m_vld[mq] = 1'b1;
    end
    if (cons) m_vld[q] = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, let the pipeline drop its request.
  task automatic step(input logic mrv, input int mrq, input logic mrb, input logic fl, input logic r);
    rst        = r;
    i_mr_valid = mrv;
    i_mr_qidx  = 3'(mrq);
    i_mr_bit   = mrb;
    i_fmr_req  = want;
    i_fmr_qidx = 3'(wq);
    i_flush    = fl;
    exp_stall  = want && !m_resp && !fl;
    @(posedge clk);
    model_update();
    #1;
    if (r) want = 1'b0;
    else if (want && !exp_stall) want = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("stall", {31'b0, o_stall}, {31'b0, exp_stall});
      check("meas_data", o_meas_data, m_data);
      check("timeout_err", {31'b0, o_timeout_err}, {31'b0, m_terr});
      check("overrun", {31'b0, o_overrun}, {31'b0, m_ovr});
      if (o_fmr_done) begin
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("resp_data", o_meas_data, sb.pop_front());
      end
    end
    if (final_req && !final_done) begin
      check("responses_outstanding", sb.size(), 32'd0);
      final_done = 1'b1;
    end
  end

  initial begin
    want = 1'b0; wq = 0;
    m_bit = '0; m_vld = '0; m_pend = 0; m_resp = 0; m_terr = 0; m_ovr = 0;
    m_data = '0; m_waited = 0; exp_stall = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    mon_on = 1'b1;
    idle(2);
    // Stored result fetched later.
    step(1'b1, 3, 1'b1, 1'b0, 1'b0);
    idle(1);
    want = 1'b1; wq = 3;
    idle(3);
    // Request waits ten cycles for its result.
    want = 1'b1; wq = 5;
    idle(10);
    step(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Timeout with no result.
    want = 1'b1; wq = 2;
    idle(20);
    // Same-cycle bypass, then a second fetch of the consumed slot stalls until flushed.
    want = 1'b1; wq = 1;
    step(1'b1, 1, 1'b1, 1'b0, 1'b0);
    idle(2);
    want = 1'b1; wq = 1;
    idle(4);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // Overwrite of an unconsumed result.
    step(1'b1, 4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b0, 1'b0);
    want = 1'b1; wq = 4;
    idle(3);
    // Flush and reset while waiting.
    want = 1'b1; wq = 6;
    idle(3);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(2);
    want = 1'b1; wq = 0;
    idle(3);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Out-of-range index.
    want = 1'b1; wq = 7;
    idle(3);
    for (int c = 0; c < 3000; c++) begin
      if (!want && !m_resp && $urandom_range(0, 3) == 0) begin
        want = 1'b1;
        wq   = $urandom_range(0, 7);
      end
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0), (m_pend && $urandom_range(0, 199) == 0));
    end
    want = 1'b0;
    idle(4);
    final_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
